// File: rtl/multdiv_unit.sv
// -----------------------------------------------------------------------------
// multdiv_unit
//
// 32-bit signed multiply / divide unit.
//   * Multiply: radix-2 Booth, 32 iterations. Each iteration works on a 65-bit
//     {acc, multiplier, q-1} register and ends with an arithmetic right shift.
//   * Divide: signed non-restoring division, 32 iterations, on operand
//     magnitudes. The quotient sign is applied at the end. The remainder is
//     discarded.
//
// The result is produced 33 cycles after the start cycle. A new start pulse
// always restarts the unit, and the operation in flight is dropped silently.
//
// Configuration macro:
//   MULTDIV_DIV_EN  defined   -> divide datapath is built.
//                   undefined -> no divide datapath. ctrl_DIV answers on the
//                                next cycle with result 0 and exception 1.
//
// Ports:
//   clock           in   rising-edge clock
//   reset           in   synchronous, active-high reset
//   data_operandA   in   [31:0] signed multiplicand / dividend
//   data_operandB   in   [31:0] signed multiplier / divisor
//   ctrl_MULT       in   one-cycle start pulse for multiply (wins over DIV)
//   ctrl_DIV        in   one-cycle start pulse for divide
//   data_result     out  [31:0] product low word / quotient (held)
//   data_exception  out  overflow / divide-by-zero flag (held)
//   data_resultRDY  out  one-cycle pulse, result valid
// -----------------------------------------------------------------------------
module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [4:0]  count_r;
  logic        last_iter_s;

  // Booth datapath: [64:33] acc, [32:1] multiplier, [0] q-1
  logic [64:0] booth_r;
  logic [64:0] booth_next_s;
  logic [31:0] mcand_r;
  logic [32:0] acc_ext_s;
  logic [32:0] addend_s;
  logic [32:0] booth_sum_s;
  logic        booth_cin_s;
  logic        mul_ovf_s;

  logic [31:0] result_r;
  logic        exc_r;
  logic        rdy_r;

  // Two's-complement negation as invert-plus-one
  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = ~v + 32'd1;
  endfunction

`ifdef MULTDIV_DIV_EN
  // Partial remainder is kept in 34 bits so the left shift of a remainder
  // near +/-2^31 cannot lose its sign.
  logic [33:0] rem_r;
  logic [33:0] rem_shift_s;
  logic [33:0] dvsr_ext_s;
  logic [33:0] rem_next_s;
  logic [31:0] quo_r;
  logic [31:0] dvsr_r;
  logic [31:0] quo_next_s;
  logic [31:0] quo_final_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic        q_neg_r;
  logic        div_zero_r;
  logic        div_ovf_r;
`endif

  assign last_iter_s = (count_r == 5'd31);

  // Booth step: choose +M, -M (as ~M + 1) or 0, add into the sign-extended acc, then shift right arithmetically
  always_comb begin
    acc_ext_s   = {booth_r[64], booth_r[64:33]};
    addend_s    = 33'd0;
    booth_cin_s = 1'b0;
    case (booth_r[1:0])
      2'b01: begin
        addend_s    = {mcand_r[31], mcand_r};
        booth_cin_s = 1'b0;
      end
      2'b10: begin
        addend_s    = ~{mcand_r[31], mcand_r};
        booth_cin_s = 1'b1;
      end
      default: begin
        addend_s    = 33'd0;
        booth_cin_s = 1'b0;
      end
    endcase
    // The sum is 33 bits wide so acc - (-2^31) cannot overflow. The shift
    // brings it back into range.
    booth_sum_s  = acc_ext_s + addend_s + {32'd0, booth_cin_s};
    booth_next_s = {booth_sum_s[32:1], booth_sum_s[0], booth_r[32:2], booth_r[1]};
    // The product is booth_next_s[64:1]. It overflows 32 bits unless bits [63:31] are all equal.
    mul_ovf_s    = ~((booth_next_s[64:32] == {33{1'b0}}) |
                     (booth_next_s[64:32] == {33{1'b1}}));
  end

`ifdef MULTDIV_DIV_EN
  // Non-restoring step plus operand magnitudes and final quotient sign
  always_comb begin
    rem_shift_s = {rem_r[32:0], quo_r[31]};
    dvsr_ext_s  = {2'b00, dvsr_r};
    if (rem_r[33] == 1'b0) begin
      rem_next_s = rem_shift_s + ~dvsr_ext_s + 34'd1;
    end else begin
      rem_next_s = rem_shift_s + dvsr_ext_s;
    end
    // A quotient bit is 1 when the new partial remainder is non-negative.
    quo_next_s  = {quo_r[30:0], ~rem_next_s[33]};
    quo_final_s = q_neg_r ? neg32(quo_next_s) : quo_next_s;
    a_mag_s     = data_operandA[31] ? neg32(data_operandA) : data_operandA;
    b_mag_s     = data_operandB[31] ? neg32(data_operandB) : data_operandB;
  end
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: a start pulse restarts from any state, and MULT has priority
  always_comb begin
    state_s = state_r;
    if (ctrl_MULT) begin
      state_s = MULT;
    end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
      state_s = DIV;
`else
      state_s = DONE;
`endif
    end else begin
      case (state_r)
        IDLE:    state_s = IDLE;
        MULT:    state_s = last_iter_s ? DONE : MULT;
        DIV:     state_s = last_iter_s ? DONE : DIV;
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs. Results load on the edge into DONE, so RDY is high during DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r    <= 5'd0;
      booth_r    <= 65'd0;
      mcand_r    <= 32'd0;
      result_r   <= 32'd0;
      exc_r      <= 1'b0;
      rdy_r      <= 1'b0;
`ifdef MULTDIV_DIV_EN
      rem_r      <= 34'd0;
      quo_r      <= 32'd0;
      dvsr_r     <= 32'd0;
      q_neg_r    <= 1'b0;
      div_zero_r <= 1'b0;
      div_ovf_r  <= 1'b0;
`endif
    end else begin
      rdy_r <= 1'b0;
      if (ctrl_MULT) begin
        count_r <= 5'd0;
        mcand_r <= data_operandA;
        booth_r <= {32'd0, data_operandB, 1'b0};
      end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
        count_r    <= 5'd0;
        rem_r      <= 34'd0;
        quo_r      <= a_mag_s;
        dvsr_r     <= b_mag_s;
        q_neg_r    <= data_operandA[31] ^ data_operandB[31];
        div_zero_r <= (data_operandB == 32'd0);
        div_ovf_r  <= (data_operandA == 32'h8000_0000) &&
                      (data_operandB == 32'hFFFF_FFFF);
`else
        count_r  <= 5'd0;
        result_r <= 32'd0;
        exc_r    <= 1'b1;
        rdy_r    <= 1'b1;
`endif
      end else begin
        case (state_r)
          MULT: begin
            booth_r <= booth_next_s;
            count_r <= count_r + 5'd1;
            if (last_iter_s) begin
              result_r <= booth_next_s[32:1];
              exc_r    <= mul_ovf_s;
              rdy_r    <= 1'b1;
            end
          end
`ifdef MULTDIV_DIV_EN
          DIV: begin
            rem_r   <= rem_next_s;
            quo_r   <= quo_next_s;
            count_r <= count_r + 5'd1;
            if (last_iter_s) begin
              if (div_zero_r) begin
                result_r <= 32'd0;
                exc_r    <= 1'b1;
              end else begin
                result_r <= quo_final_s;
                exc_r    <= div_ovf_r;
              end
              rdy_r <= 1'b1;
            end
          end
`endif
          default: begin
            count_r <= 5'd0;
          end
        endcase
      end
    end
  end

  assign data_result    = result_r;
  assign data_exception = exc_r;
  assign data_resultRDY = rdy_r;

endmodule

// File: tb/tb_multdiv_unit.sv
// -----------------------------------------------------------------------------
// tb_multdiv_unit
//
// Scoreboard bench for multdiv_unit. Each issued operation pushes the result
// and exception flag it expects, together with the cycle in which RDY is
// expected. A negedge monitor checks RDY every cycle and pops entries as RDY
// arrives. It also checks that result and exception hold their last completed
// values. Reference values come from a behavioural model, not from the design.
// Honours MULTDIV_DIV_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] held_res = 32'd0;
  logic        held_exc = 1'b0;
  logic        rst_q = 1'b0;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Cycle count and the reset value the design sampled
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model_mul(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    sa    = {{32{a[31]}}, a};
    sb    = {{32{b[31]}}, b};
    p     = sa * sb;
    e.res = p[31:0];
    e.exc = !((p[63:31] == {33{1'b0}}) || (p[63:31] == {33{1'b1}}));
    e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t model_div(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa    = a;
    sb    = b;
    e.cyc = 0;
`ifdef MULTDIV_DIV_EN
    if (b == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      e.res = sa / sb;
      e.exc = 1'b0;
    end
`else
    e.res = 32'd0;
    e.exc = 1'b1;
    if (sa == sb) e.cyc = 0;
`endif
    return e;
  endfunction

  // Monitor: RDY timing, result/exception values and hold behaviour
  always @(negedge clock) begin
    logic exp_rdy;
    exp_t e;
    if (rst_q) begin
      held_res = 32'd0;
      held_exc = 1'b0;
    end
    exp_rdy = (sb_q.size() != 0) && (sb_q[0].cyc == cyc);
    check_val("rdy", {31'd0, data_resultRDY}, {31'd0, exp_rdy});
    if (data_resultRDY && sb_q.size() != 0) begin
      e        = sb_q.pop_front();
      held_res = e.res;
      held_exc = e.exc;
    end else if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
      e = sb_q.pop_front();
    end
    check_val("result", data_result, held_res);
    check_val("exception", {31'd0, data_exception}, {31'd0, held_exc});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive a one-cycle start pulse and record what it should produce
  task automatic issue(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul;
    ctrl_DIV      = dv;
    // Any operation still in flight gets abandoned
    while (sb_q.size() != 0 && sb_q[sb_q.size()-1].cyc > cyc) void'(sb_q.pop_back());
    if (mul) begin
      e     = model_mul(a, b);
      e.cyc = cyc + 33;
    end else begin
      e = model_div(a, b);
`ifdef MULTDIV_DIV_EN
      e.cyc = cyc + 33;
`else
      e.cyc = cyc + 1;
`endif
    end
    sb_q.push_back(e);
    tick();
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
    check_val("drain", 32'(sb_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Directed multiplies
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);           wait_done();
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);   wait_done();
    issue(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);   wait_done();
    issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done();
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   wait_done();
    issue(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0002);   wait_done();

    // Directed divides
    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);           wait_done();
    issue(1'b0, 1'b1, 32'd5, 32'd0);                   wait_done();
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done();
    issue(1'b0, 1'b1, 32'd100, 32'd7);                 wait_done();
    issue(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);           wait_done();
    issue(1'b0, 1'b1, 32'd0, 32'd5);                   wait_done();
    issue(1'b0, 1'b1, 32'h8000_0000, 32'd1);           wait_done();
    issue(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);   wait_done();

    // Both starts together: multiply wins
    issue(1'b1, 1'b1, 32'd9, 32'd11);                  wait_done();

    // Multiply abandoned by a divide ten cycles later
    issue(1'b1, 1'b0, 32'd123, 32'd456);
    for (int i = 0; i < 9; i++) tick();
    issue(1'b0, 1'b1, 32'd100, 32'd7);                 wait_done();

    // Reset five cycles into a multiply: no RDY, outputs cleared
    issue(1'b1, 1'b0, 32'd3, 32'd5);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    sb_q.delete();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    // Result to hold, then reset colliding with a start pulse
    issue(1'b1, 1'b0, 32'd6, 32'd7);                   wait_done();
    reset         = 1'b1;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'd2;
    tick();
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = (n % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (n % 4 == 1) a = {{20{a[31]}}, a[11:0]};
      issue(n[0], ~n[0], a, b);
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
